// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared constants for the two-port memory arbiter.
//   - FSM state encodings (IDLE/CMD/RD/WR/DONE) as plain localparams
//   - requester port indices (ARB_INSTR, ARB_DATA)
//   - beat_cnt_w(): width of the beat counter for a given burst length (min 1)
package mem_arb_pkg;

  typedef logic [2:0] arb_state_t;

  localparam arb_state_t IDLE = 3'd0;
  localparam arb_state_t CMD  = 3'd1;
  localparam arb_state_t RD   = 3'd2;
  localparam arb_state_t WR   = 3'd3;
  localparam arb_state_t DONE = 3'd4;

  localparam int unsigned ARB_INSTR = 0;
  localparam int unsigned ARB_DATA  = 1;

  // A one-beat burst still needs a 1-bit counter so beat_idx has a legal width.
  function automatic int unsigned beat_cnt_w(input int unsigned burst_len);
    return (burst_len <= 2) ? 1 : $clog2(burst_len);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: burst bus between the arbiter and main memory.
//   master (arbiter): mem_req_valid/addr/we, mem_wvalid/mem_wdata out;
//                     mem_req_ready, mem_wready, mem_rvalid/mem_rdata in.
//   slave (memory):   the mirror image.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wvalid;
  logic              mem_wready;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_we, mem_wdata, mem_wvalid,
    input  mem_req_ready, mem_wready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_we, mem_wdata, mem_wvalid,
    output mem_req_ready, mem_wready, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: combinational 2-way round-robin pick.
//   req      in  2  request bits (bit0 = instr, bit1 = data)
//   last_gnt in  1  index of the port granted most recently
//   win      out 2  one-hot winner, 0 when nobody requests
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      // Under contention the port that did not go last wins.
      2'b11:   win = (last_gnt == 1'(ARB_DATA)) ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one burst memory port between the instruction side
// (port 0) and the data side (port 1) with round-robin arbitration.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_we [1:0]        per-requester request and direction
//   req_addr0/1, req_wdata0/1     per-requester line address and write beat
//   gnt, done, rsp_valid [1:0]    one-hot grant, end-of-burst pulse, read valid
//   beat_idx, rsp_data            current beat number, read data pass-through
//   mem                           mem_arbiter_if.master burst bus to memory
// Optional (macro MEM_ARB_STATS_EN): stat_gnt0, stat_gnt1, stat_wait, 32-bit
// saturating counters of completed bursts per port and of waiting cycles.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BURST_LEN = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [1:0]                         req_valid,
  input  logic [1:0]                         req_we,
  input  logic [ADDR_W-1:0]                  req_addr0,
  input  logic [ADDR_W-1:0]                  req_addr1,
  input  logic [DATA_W-1:0]                  req_wdata0,
  input  logic [DATA_W-1:0]                  req_wdata1,
  output logic [1:0]                         gnt,
  output logic [beat_cnt_w(BURST_LEN)-1:0]   beat_idx,
  output logic [1:0]                         rsp_valid,
  output logic [DATA_W-1:0]                  rsp_data,
  output logic [1:0]                         done,
`ifdef MEM_ARB_STATS_EN
  output logic [31:0]                        stat_gnt0,
  output logic [31:0]                        stat_gnt1,
  output logic [31:0]                        stat_wait,
`endif
  mem_arbiter_if.master                      mem
);

  localparam int unsigned CntW = beat_cnt_w(BURST_LEN);
  localparam int unsigned OffW = $clog2(BURST_LEN * DATA_W / 8);
  localparam logic [ADDR_W-1:0] AddrMask = ~((ADDR_W'(1) << OffW) - ADDR_W'(1));
  localparam logic [CntW-1:0]   LastBeat = CntW'(BURST_LEN - 1);

  arb_state_t        state_q, state_d;
  logic              sel_q, sel_d;           // index of the port owning the burst
  logic              last_gnt_q, last_gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CntW-1:0]   cnt_inc;
  logic [1:0]        win;
  logic [1:0]        sel_oh;
  logic              busy;

  rr_arb2 u_rr_arb2 (
    .req      (req_valid),
    .last_gnt (last_gnt_q),
    .win      (win)
  );

  assign sel_oh[ARB_INSTR] = (sel_q == 1'(ARB_INSTR));
  assign sel_oh[ARB_DATA]  = (sel_q == 1'(ARB_DATA));
  // Explicit wrap keeps BURST_LEN = 1 pinned at 0.
  assign cnt_inc = (cnt_q == LastBeat) ? '0 : cnt_q + CntW'(1);
  assign busy    = (state_q == CMD) || (state_q == RD) || (state_q == WR);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_gnt_d = last_gnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (|win) begin
          sel_d      = win[ARB_DATA];
          last_gnt_d = win[ARB_DATA];
          addr_d     = (win[ARB_DATA] ? req_addr1 : req_addr0) & AddrMask;
          we_d       = win[ARB_DATA] ? req_we[ARB_DATA] : req_we[ARB_INSTR];
          cnt_d      = '0;
          state_d    = CMD;
        end
      end
      CMD: begin
        if (mem.mem_req_ready) state_d = we_q ? WR : RD;
      end
      RD: begin
        if (mem.mem_rvalid) begin
          cnt_d = cnt_inc;
          if (cnt_q == LastBeat) state_d = DONE;
        end
      end
      WR: begin
        if (mem.mem_wready) begin
          cnt_d = cnt_inc;
          if (cnt_q == LastBeat) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      last_gnt_q <= 1'(ARB_DATA);
      addr_q     <= '0;
      we_q       <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_gnt_q <= last_gnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
    end
  end

  // Every output is decoded from registered state so reset forces all to 0.
  assign gnt       = busy ? sel_oh : 2'b00;
  assign done      = (state_q == DONE) ? sel_oh : 2'b00;
  assign beat_idx  = cnt_q;
  assign rsp_valid = ((state_q == RD) && mem.mem_rvalid) ? sel_oh : 2'b00;
  assign rsp_data  = ((state_q == RD) && mem.mem_rvalid) ? mem.mem_rdata : '0;

  assign mem.mem_req_valid = (state_q == CMD);
  assign mem.mem_req_addr  = (state_q == CMD) ? addr_q : '0;
  assign mem.mem_req_we    = (state_q == CMD) ? we_q : 1'b0;
  assign mem.mem_wvalid    = (state_q == WR);
  assign mem.mem_wdata     = (state_q == WR) ? (sel_q ? req_wdata1 : req_wdata0) : '0;

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_gnt0 <= '0;
      stat_gnt1 <= '0;
      stat_wait <= '0;
    end else begin
      if ((state_q == DONE) && (sel_q == 1'(ARB_INSTR)) && (stat_gnt0 != '1)) begin
        stat_gnt0 <= stat_gnt0 + 32'd1;
      end
      if ((state_q == DONE) && (sel_q == 1'(ARB_DATA)) && (stat_gnt1 != '1)) begin
        stat_gnt1 <= stat_gnt1 + 32'd1;
      end
      if ((|(req_valid & ~gnt)) && (stat_wait != '1)) begin
        stat_wait <= stat_wait + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BURST_LEN = 16;
  localparam int unsigned IdxW      = (BURST_LEN <= 2) ? 1 : $clog2(BURST_LEN);
  localparam logic [ADDR_W-1:0] LineBytes = ADDR_W'(BURST_LEN * DATA_W / 8);
  localparam logic [ADDR_W-1:0] LineMask  = ~(LineBytes - ADDR_W'(1));
  localparam logic [DATA_W-1:0] WStep     = 32'h0101_0101;

  logic              clk;
  logic              rst;
  logic [1:0]        req_valid, req_we;
  logic [ADDR_W-1:0] req_addr0, req_addr1;
  logic [DATA_W-1:0] req_wdata0, req_wdata1;
  logic [DATA_W-1:0] wbase0, wbase1;
  logic [1:0]        gnt, rsp_valid, done;
  logic [IdxW-1:0]   beat_idx;
  logic [DATA_W-1:0] rsp_data;
`ifdef MEM_ARB_STATS_EN
  logic [31:0]       stat_gnt0, stat_gnt1, stat_wait;
`endif

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr0  (req_addr0),
    .req_addr1  (req_addr1),
    .req_wdata0 (req_wdata0),
    .req_wdata1 (req_wdata1),
    .gnt        (gnt),
    .beat_idx   (beat_idx),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .done       (done),
`ifdef MEM_ARB_STATS_EN
    .stat_gnt0  (stat_gnt0),
    .stat_gnt1  (stat_gnt1),
    .stat_wait  (stat_wait),
`endif
    .mem        (mem_bus)
  );

  // Requesters present the write beat for the current beat_idx combinationally.
  assign req_wdata0 = wbase0 + DATA_W'(beat_idx) * WStep;
  assign req_wdata1 = wbase1 + DATA_W'(beat_idx) * WStep;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int model_last   = 1;  // reference: port granted most recently

  logic [DATA_W-1:0] rd_data [BURST_LEN];
  logic [1:0]        obs_rsp_valid [BURST_LEN];
  logic [DATA_W-1:0] obs_data [BURST_LEN];
  logic [IdxW-1:0]   obs_idx [BURST_LEN];
  logic [ADDR_W-1:0] obs_addr;
  logic              obs_we;
  logic [1:0]        obs_gnt, obs_done, obs_gnt_at_done;
  int obs_beats, obs_hold_bad, obs_spurious, obs_early_done, obs_timeout;

  function automatic int pick(input logic [1:0] req, input int last);
    if (req == 2'b11) return 1 - last;
    return req[1] ? 1 : 0;
  endfunction

  function automatic logic [1:0] onehot(input int port);
    return (port == 1) ? 2'b10 : 2'b01;
  endfunction

  // Plays the memory for one burst and records what the arbiter showed.
  // Entered and left just after a falling edge; returns in the DONE cycle.
  task automatic serve_burst(input int unsigned cmd_delay, input bit wr_toggle);
    int unsigned cyc;
    int unsigned beat;
    bit wr_phase;
    obs_timeout = 0; obs_hold_bad = 0; obs_spurious = 0; obs_early_done = 0; obs_beats = 0;
    cyc = 0;
    while (mem_bus.mem_req_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk); #1; cyc++;
    end
    if (mem_bus.mem_req_valid !== 1'b1) begin
      obs_timeout = 1;
      return;
    end
    obs_addr = mem_bus.mem_req_addr;
    obs_we   = mem_bus.mem_req_we;
    obs_gnt  = gnt;
    for (int i = 0; i < int'(cmd_delay); i++) begin
      mem_bus.mem_rvalid = 1'($urandom_range(0, 1));
      mem_bus.mem_rdata  = $urandom;
      #1;
      if (rsp_valid !== 2'b00) obs_spurious++;
      if (mem_bus.mem_req_valid !== 1'b1 || mem_bus.mem_req_addr !== obs_addr ||
          mem_bus.mem_req_we !== obs_we) obs_hold_bad++;
      @(negedge clk); #1;
    end
    mem_bus.mem_rvalid    = 1'b0;
    mem_bus.mem_req_ready = 1'b1;
    @(negedge clk);
    mem_bus.mem_req_ready = 1'b0;
    beat = 0; cyc = 0; wr_phase = 1'b1;
    while (beat < BURST_LEN && cyc < 400) begin
      if (!obs_we) begin
        mem_bus.mem_rvalid = ($urandom_range(0, 3) != 0);
        mem_bus.mem_rdata  = mem_bus.mem_rvalid ? rd_data[beat] : $urandom;
        #1;
        if (mem_bus.mem_rvalid) begin
          obs_rsp_valid[beat] = rsp_valid;
          obs_data[beat]      = rsp_data;
          obs_idx[beat]       = beat_idx;
          beat++;
        end else if (rsp_valid !== 2'b00) obs_spurious++;
      end else begin
        mem_bus.mem_wready = wr_toggle ? wr_phase : 1'($urandom_range(0, 1));
        wr_phase = !wr_phase;
        #1;
        if (mem_bus.mem_wvalid !== 1'b1 || rsp_valid !== 2'b00) obs_hold_bad++;
        if (mem_bus.mem_wready) begin
          obs_data[beat] = mem_bus.mem_wdata;
          obs_idx[beat]  = beat_idx;
          beat++;
        end
      end
      if (done !== 2'b00) obs_early_done++;
      @(negedge clk); cyc++;
    end
    mem_bus.mem_rvalid = 1'b0;
    mem_bus.mem_wready = 1'b0;
    obs_beats = int'(beat);
    #1;
    obs_done        = done;
    obs_gnt_at_done = gnt;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b00;
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if (gnt !== 2'b00 || done !== 2'b00 || rsp_valid !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_ctrl: gnt=%b done=%b rsp_valid=%b, required all 00",
               gnt, done, rsp_valid);
    end
    tests_run++;
    if (beat_idx !== '0 || rsp_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: beat_idx=%0d rsp_data=%h, required 0", beat_idx, rsp_data);
    end
    tests_run++;
    if (mem_bus.mem_req_valid !== 1'b0 || mem_bus.mem_wvalid !== 1'b0 ||
        mem_bus.mem_req_addr !== '0 || mem_bus.mem_req_we !== 1'b0 || mem_bus.mem_wdata !== '0) begin
      tests_failed++;
      $display("FAIL reset_mem: req_valid=%b wvalid=%b addr=%h we=%b wdata=%h, required 0",
               mem_bus.mem_req_valid, mem_bus.mem_wvalid, mem_bus.mem_req_addr,
               mem_bus.mem_req_we, mem_bus.mem_wdata);
    end
`ifdef MEM_ARB_STATS_EN
    tests_run++;
    if (stat_gnt0 !== 0 || stat_gnt1 !== 0 || stat_wait !== 0) begin
      tests_failed++;
      $display("FAIL reset_stats: %0d %0d %0d, required 0 0 0", stat_gnt0, stat_gnt1, stat_wait);
    end
`endif
    rst = 1'b0;
    model_last = 1;
  endtask

  task automatic test_single_read();
    for (int i = 0; i < int'(BURST_LEN); i++) rd_data[i] = DATA_W'(i);
    req_valid = 2'b01; req_we = 2'b00; req_addr0 = 32'h0000_1004;
    @(negedge clk); #1;
    tests_run++;
    if (gnt !== 2'b01 || mem_bus.mem_req_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_latency: gnt=%b mem_req_valid=%b, required 01/1",
               gnt, mem_bus.mem_req_valid);
    end
    serve_burst(0, 1'b0);
    req_valid = 2'b00;
    model_last = 0;
    tests_run++;
    if (obs_timeout != 0 || obs_beats != int'(BURST_LEN)) begin
      tests_failed++;
      $display("FAIL single_beats: timeout=%0d beats=%0d, required 0/%0d",
               obs_timeout, obs_beats, BURST_LEN);
    end
    tests_run++;
    if (obs_addr !== 32'h0000_1000 || obs_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_cmd: addr=%h we=%b, required 00001000/0", obs_addr, obs_we);
    end
    for (int i = 0; i < int'(BURST_LEN); i++) begin
      tests_run++;
      if (obs_rsp_valid[i] !== 2'b01 || obs_data[i] !== DATA_W'(i) || obs_idx[i] !== IdxW'(i)) begin
        tests_failed++;
        $display("FAIL single_beat%0d: rsp_valid=%b data=%h idx=%0d, required 01/%h/%0d",
                 i, obs_rsp_valid[i], obs_data[i], obs_idx[i], i, i);
      end
    end
    tests_run++;
    if (obs_done !== 2'b01 || obs_gnt_at_done !== 2'b00 || obs_spurious != 0) begin
      tests_failed++;
      $display("FAIL single_done: done=%b gnt=%b spurious=%0d, required 01/00/0",
               obs_done, obs_gnt_at_done, obs_spurious);
    end
    @(negedge clk); #1;
    tests_run++;
    if (done !== 2'b00 || gnt !== 2'b00) begin
      tests_failed++;
      $display("FAIL single_pulse: done=%b gnt=%b after pulse, required 00/00", done, gnt);
    end
  endtask

  task automatic test_cmd_backpressure();
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < int'(BURST_LEN); i++) rd_data[i] = $urandom;
    a = $urandom;
    req_valid = 2'b01; req_we = 2'b00; req_addr0 = a;
    serve_burst(5, 1'b0);
    req_valid = 2'b00;
    model_last = pick(2'b01, model_last);
    tests_run++;
    if (obs_timeout != 0 || obs_hold_bad != 0 || obs_spurious != 0) begin
      tests_failed++;
      $display("FAIL bp_hold: timeout=%0d unstable=%0d spurious_rsp=%0d, required 0/0/0",
               obs_timeout, obs_hold_bad, obs_spurious);
    end
    tests_run++;
    if (obs_addr !== (a & LineMask)) begin
      tests_failed++;
      $display("FAIL bp_addr: addr=%h, required %h", obs_addr, a & LineMask);
    end
    for (int i = 0; i < int'(BURST_LEN); i++) begin
      tests_run++;
      if (obs_data[i] !== rd_data[i] || obs_rsp_valid[i] !== 2'b01) begin
        tests_failed++;
        $display("FAIL bp_beat%0d: data=%h valid=%b, required %h/01",
                 i, obs_data[i], obs_rsp_valid[i], rd_data[i]);
      end
    end
    @(negedge clk); #1;
  endtask

  task automatic test_write_burst();
    logic [ADDR_W-1:0] a;
    a = $urandom; wbase1 = $urandom;
    req_valid = 2'b10; req_we = 2'b10; req_addr1 = a;
    serve_burst(0, 1'b1);
    req_valid = 2'b00; req_we = 2'b00;
    model_last = pick(2'b10, model_last);
    tests_run++;
    if (obs_timeout != 0 || obs_beats != int'(BURST_LEN) || obs_gnt !== 2'b10 || obs_we !== 1'b1) begin
      tests_failed++;
      $display("FAIL wr_cmd: timeout=%0d beats=%0d gnt=%b we=%b, required 0/%0d/10/1",
               obs_timeout, obs_beats, BURST_LEN, obs_gnt, obs_we);
    end
    tests_run++;
    if (obs_addr !== (a & LineMask)) begin
      tests_failed++;
      $display("FAIL wr_addr: addr=%h, required %h", obs_addr, a & LineMask);
    end
    for (int i = 0; i < int'(BURST_LEN); i++) begin
      tests_run++;
      if (obs_data[i] !== wbase1 + DATA_W'(i) * WStep || obs_idx[i] !== IdxW'(i)) begin
        tests_failed++;
        $display("FAIL wr_beat%0d: wdata=%h idx=%0d, required %h/%0d",
                 i, obs_data[i], obs_idx[i], wbase1 + DATA_W'(i) * WStep, i);
      end
    end
    tests_run++;
    if (obs_early_done != 0 || obs_hold_bad != 0 || obs_done !== 2'b10) begin
      tests_failed++;
      $display("FAIL wr_done: early=%0d wvalid_bad=%0d done=%b, required 0/0/10",
               obs_early_done, obs_hold_bad, obs_done);
    end
    @(negedge clk); #1;
    tests_run++;
    if (done !== 2'b00) begin
      tests_failed++;
      $display("FAIL wr_pulse: done=%b after pulse, required 00", done);
    end
  endtask

  task automatic test_contention();
    int win;
    int ndone [2];
    logic [ADDR_W-1:0] a0, a1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; model_last = 1;
    ndone[0] = 0; ndone[1] = 0;
    a0 = $urandom; a1 = $urandom;
    req_valid = 2'b11; req_we = 2'b00; req_addr0 = a0; req_addr1 = a1;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < int'(BURST_LEN); i++) rd_data[i] = $urandom;
      win = pick(2'b11, model_last);
      serve_burst($urandom_range(0, 2), 1'b0);
      if (k == 3) req_valid = 2'b00;
      model_last = win;
      if (obs_done == 2'b01) ndone[0]++;
      if (obs_done == 2'b10) ndone[1]++;
      tests_run++;
      if (obs_timeout != 0 || obs_gnt !== onehot(win) || obs_done !== onehot(win)) begin
        tests_failed++;
        $display("FAIL cont_gnt%0d: timeout=%0d gnt=%b done=%b, required 0/%b/%b",
                 k, obs_timeout, obs_gnt, obs_done, onehot(win), onehot(win));
      end
      tests_run++;
      if (obs_addr !== (((win == 1) ? a1 : a0) & LineMask)) begin
        tests_failed++;
        $display("FAIL cont_addr%0d: addr=%h, required %h",
                 k, obs_addr, ((win == 1) ? a1 : a0) & LineMask);
      end
      for (int i = 0; i < int'(BURST_LEN); i++) begin
        tests_run++;
        if (obs_data[i] !== rd_data[i] || obs_rsp_valid[i] !== onehot(win)) begin
          tests_failed++;
          $display("FAIL cont_beat%0d_%0d: data=%h valid=%b, required %h/%b",
                   k, i, obs_data[i], obs_rsp_valid[i], rd_data[i], onehot(win));
        end
      end
    end
    @(negedge clk); #1;
    tests_run++;
    if (ndone[0] != 2 || ndone[1] != 2) begin
      tests_failed++;
      $display("FAIL cont_balance: done0=%0d done1=%0d, required 2/2", ndone[0], ndone[1]);
    end
`ifdef MEM_ARB_STATS_EN
    tests_run++;
    if (stat_gnt0 !== 32'd2 || stat_gnt1 !== 32'd2 || stat_wait == 32'd0) begin
      tests_failed++;
      $display("FAIL stats_count: gnt0=%0d gnt1=%0d wait=%0d, required 2/2/>0",
               stat_gnt0, stat_gnt1, stat_wait);
    end
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0; model_last = 1;
    tests_run++;
    if (stat_gnt0 !== 0 || stat_gnt1 !== 0 || stat_wait !== 0) begin
      tests_failed++;
      $display("FAIL stats_clear: %0d %0d %0d, required 0 0 0", stat_gnt0, stat_gnt1, stat_wait);
    end
`endif
  endtask

  task automatic test_reset_mid_read();
    int cyc;
    req_valid = 2'b01; req_we = 2'b00; req_addr0 = $urandom;
    cyc = 0;
    while (mem_bus.mem_req_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk); #1; cyc++;
    end
    tests_run++;
    if (mem_bus.mem_req_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_cmd: mem_req_valid=%b, required 1", mem_bus.mem_req_valid);
    end
    mem_bus.mem_req_ready = 1'b1;
    @(negedge clk);
    mem_bus.mem_req_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = $urandom;
      @(negedge clk);
    end
    mem_bus.mem_rvalid = 1'b1; rst = 1'b1;
    #1;
    tests_run++;
    if (beat_idx !== IdxW'(7) || rsp_valid !== 2'b01) begin
      tests_failed++;
      $display("FAIL rst_mid_beat7: idx=%0d rsp_valid=%b, required 7/01", beat_idx, rsp_valid);
    end
    @(negedge clk); #1;
    tests_run++;
    if (gnt !== 2'b00 || rsp_valid !== 2'b00 || done !== 2'b00 || beat_idx !== '0 ||
        mem_bus.mem_req_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_outs: gnt=%b rsp=%b done=%b idx=%0d req=%b, required all 0",
               gnt, rsp_valid, done, beat_idx, mem_bus.mem_req_valid);
    end
    rst = 1'b0; model_last = 1;
    mem_bus.mem_rvalid = 1'b0;
    req_valid = 2'b11; req_addr1 = $urandom;
    @(negedge clk); #1;
    tests_run++;
    if (gnt !== onehot(pick(2'b11, model_last))) begin
      tests_failed++;
      $display("FAIL rst_tie: gnt=%b, required %b", gnt, onehot(pick(2'b11, model_last)));
    end
    model_last = pick(2'b11, model_last);
    for (int i = 0; i < int'(BURST_LEN); i++) rd_data[i] = $urandom;
    serve_burst(0, 1'b0);
    req_valid = 2'b10;
    tests_run++;
    if (obs_done !== 2'b01) begin
      tests_failed++;
      $display("FAIL rst_after0: done=%b, required 01", obs_done);
    end
    serve_burst(1, 1'b0);
    req_valid = 2'b00;
    model_last = pick(2'b10, model_last);
    tests_run++;
    if (obs_gnt !== 2'b10 || obs_done !== 2'b10 || obs_timeout != 0) begin
      tests_failed++;
      $display("FAIL rst_after1: gnt=%b done=%b timeout=%0d, required 10/10/0",
               obs_gnt, obs_done, obs_timeout);
    end
    @(negedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 2'b00; req_we = 2'b00; req_addr0 = '0; req_addr1 = '0;
    wbase0 = $urandom; wbase1 = $urandom;
    mem_bus.mem_req_ready = 1'b0; mem_bus.mem_wready = 1'b0;
    mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = '0;
    test_reset();
    test_single_read();
    test_cmd_backpressure();
    test_write_burst();
    test_contention();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
